bcd_counter_ndigit: RTL and testbench

- Parametrised, fully synchronous multi-digit BCD counter with an up/down mode, parallel load, a snapshot (hold) register and per-digit 7-segment decode of the held value.
- Successor to the 4-bit ripple counter and single-digit decoder used in the frequency-counter experiments.
- Intended as the counting and display core of the frequency counter:
  - the gate logic drives `en`;
  - the measurement controller pulses `latch` at the end of each gate window.

---
 rtl/bcd_counter_ndigit.sv | 123 ++++++++++++
 tb/tb_bcd_counter_ndigit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_ndigit.sv
// Multi-digit synchronous BCD up/down counter with parallel load, snapshot register
// and 7-segment decode of the snapshot. The full carry/borrow chain resolves in one cycle.
module bcd_counter_ndigit #(
    parameter int DIGITS         = 4,
    parameter bit ACTIVE_LOW_SEG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  latch,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   held,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  carry,
    output logic                  ovf
);

    logic [4*DIGITS-1:0] r_count;
    logic [4*DIGITS-1:0] r_held;
    logic                r_carry;
    logic                r_ovf;

    logic [4*DIGITS-1:0] w_next;
    logic [4*DIGITS-1:0] w_load_sat;
    logic                w_chain;
    logic [3:0]          w_digit;

    // Segment pattern in active-low form, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 7'b1000000;
            4'd1:    seg_pattern = 7'b1111001;
            4'd2:    seg_pattern = 7'b0100100;
            4'd3:    seg_pattern = 7'b0110000;
            4'd4:    seg_pattern = 7'b0011001;
            4'd5:    seg_pattern = 7'b0010010;
            4'd6:    seg_pattern = 7'b0000010;
            4'd7:    seg_pattern = 7'b1111000;
            4'd8:    seg_pattern = 7'b0000000;
            4'd9:    seg_pattern = 7'b0010000;
            default: seg_pattern = 7'b1111111;
        endcase
    endfunction

    // Next count: w_chain carries the increment/borrow request digit to digit.
    // When it survives past the last digit, every digit wrapped.
    always_comb begin
        w_next  = r_count;
        w_chain = 1'b1;
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            w_digit = r_count[4*i +: 4];
            if (w_chain) begin
                if (up) begin
                    if (w_digit == 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = w_digit + 4'd1;
                        w_chain          = 1'b0;
                    end
                end else begin
                    if (w_digit == 4'd0) begin
                        w_next[4*i +: 4] = 4'd9;
                    end else begin
                        w_next[4*i +: 4] = w_digit - 4'd1;
                        w_chain          = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_load_sat = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_held  <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // Snapshot takes the pre-update count, regardless of load/en.
            if (latch) begin
                r_held <= r_count;
            end
            if (load) begin
                r_count <= w_load_sat;
                r_carry <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (en) begin
                r_count <= w_next;
                r_carry <= w_chain;
                if (w_chain) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_carry <= 1'b0;
            end
        end
    end

    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            seg[7*i +: 7] = ACTIVE_LOW_SEG ? seg_pattern(r_held[4*i +: 4])
                                           : ~seg_pattern(r_held[4*i +: 4]);
        end
    end

    assign count = r_count;
    assign held  = r_held;
    assign carry = r_carry;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Directed bench for bcd_counter_ndigit (DIGITS=4, active-low segments):
// reset, up/down wrap, saturating load, priorities, latch and mid-count reset.
module tb_bcd_counter_ndigit;

    localparam int DIGITS = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic                clk;
    logic                rst;
    logic                en;
    logic                up;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic                latch;
    logic [4*DIGITS-1:0] count;
    logic [4*DIGITS-1:0] held;
    logic [7*DIGITS-1:0] seg;
    logic                carry;
    logic                ovf;

    int total;
    int bad;

    bcd_counter_ndigit #(
        .DIGITS         (DIGITS),
        .ACTIVE_LOW_SEG (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .latch    (latch),
        .count    (count),
        .held     (held),
        .seg      (seg),
        .carry    (carry),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it before checking/driving.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        latch    = 1'b0;

        // 1. reset then count up
        tick();
        chk("rst1_count", 32'(count), 32'h0);
        tick();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_held",  32'(held),  32'h0);
        chk("rst_carry", 32'(carry), 32'h0);
        chk("rst_ovf",   32'(ovf),   32'h0);
        chk("rst_seg",   32'(seg),   32'({S0, S0, S0, S0}));
        rst = 1'b0;
        en  = 1'b1;
        up  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("up_carry", 32'(carry), 32'h0);
        end
        chk("up12_count", 32'(count), 32'h0012);

        // 2. up wrap
        en       = 1'b0;
        load     = 1'b1;
        load_val = 16'h9998;
        tick();
        chk("ld9998_count", 32'(count), 32'h9998);
        load = 1'b0;
        en   = 1'b1;
        tick();
        chk("upw_9999",   32'(count), 32'h9999);
        chk("upw_c0",     32'(carry), 32'h0);
        chk("upw_ovf0",   32'(ovf),   32'h0);
        tick();
        chk("upw_0000",   32'(count), 32'h0000);
        chk("upw_c1",     32'(carry), 32'h1);
        chk("upw_ovf1",   32'(ovf),   32'h1);
        en = 1'b0;
        tick();
        chk("upw_hold",   32'(count), 32'h0000);
        chk("upw_cdrop",  32'(carry), 32'h0);
        chk("upw_ovfst",  32'(ovf),   32'h1);
        load     = 1'b1;
        load_val = 16'h0000;
        tick();
        chk("ld0_ovfclr", 32'(ovf),   32'h0);

        // 3. down wrap
        load_val = 16'h0001;
        tick();
        chk("ld0001_count", 32'(count), 32'h0001);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b0;
        tick();
        chk("dn_0000",    32'(count), 32'h0000);
        chk("dn_c0",      32'(carry), 32'h0);
        tick();
        chk("dn_9999",    32'(count), 32'h9999);
        chk("dn_c1",      32'(carry), 32'h1);
        chk("dn_ovf1",    32'(ovf),   32'h1);
        en = 1'b0;
        tick();
        chk("dn_cdrop",   32'(carry), 32'h0);
        chk("dn_ovfst",   32'(ovf),   32'h1);

        // 4. invalid load with en, plus a coinciding latch of the old count
        load     = 1'b1;
        en       = 1'b1;
        up       = 1'b1;
        latch    = 1'b1;
        load_val = 16'hA3F5;
        tick();
        chk("sat_count",  32'(count), 32'h9395);
        chk("sat_ovf",    32'(ovf),   32'h0);
        chk("sat_carry",  32'(carry), 32'h0);
        chk("sat_held",   32'(held),  32'h9999);
        chk("sat_seg",    32'(seg),   32'({S9, S9, S9, S9}));

        // 5. simultaneous latch and count
        latch    = 1'b0;
        en       = 1'b0;
        load_val = 16'h0457;
        tick();
        chk("ld0457_count", 32'(count), 32'h0457);
        load  = 1'b0;
        en    = 1'b1;
        latch = 1'b1;
        tick();
        chk("lat_held",   32'(held),  32'h0457);
        chk("lat_count",  32'(count), 32'h0458);
        chk("lat_seg_d0", 32'(seg[6:0]),  32'(S7));
        chk("lat_seg_d1", 32'(seg[13:7]), 32'(S5));
        chk("lat_seg",    32'(seg),   32'({S0, S4, S5, S7}));

        // 6. set ovf, hold with en=0, then reset with latch and a pending down-wrap
        latch    = 1'b0;
        en       = 1'b0;
        load     = 1'b1;
        load_val = 16'h9999;
        tick();
        load = 1'b0;
        en   = 1'b1;
        tick();
        chk("pre_ovf",    32'(ovf),   32'h1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en0_count", 32'(count), 32'h0000);
            chk("en0_held",  32'(held),  32'h0457);
        end
        rst   = 1'b1;
        latch = 1'b1;
        en    = 1'b1;
        up    = 1'b0;
        tick();
        chk("mrst_count", 32'(count), 32'h0);
        chk("mrst_held",  32'(held),  32'h0);
        chk("mrst_ovf",   32'(ovf),   32'h0);
        chk("mrst_carry", 32'(carry), 32'h0);
        chk("mrst_seg",   32'(seg),   32'({S0, S0, S0, S0}));
        rst   = 1'b0;
        latch = 1'b0;
        up    = 1'b1;
        tick();
        chk("resume1",    32'(count), 32'h0001);
        tick();
        chk("resume2",    32'(count), 32'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
